// File: rtl/gpio_irq_servicer.sv
// gpio_irq_servicer
// Hardware interrupt-service sequencer for the APB GPIO block. On the GPIO
// combined interrupt it reads Interrupt State (0x18), clears the set bits with
// a write-1-to-clear to the same register, and queues a timestamped record.
//
// Handshake on the event port: a record transfers on a rising PCLK edge where
// evt_valid and evt_ready are both high. evt_valid never depends on
// evt_ready, evt_status/evt_ts are stable while evt_valid is high and not
// popped, and evt_ready while the FIFO is empty has no effect.
module gpio_irq_servicer #(
    parameter int PortWidth = 8,
    parameter int TS_W      = 16,
    parameter int DEPTH     = 4,
    parameter int HOLDOFF   = 4
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic                     en,
    input  logic                     combint,
    output logic                     m_psel,
    output logic                     m_penable,
    output logic                     m_pwrite,
    output logic [7:2]               m_paddr,
    output logic [31:0]              m_pwdata,
    input  logic [31:0]              m_prdata,
    input  logic                     m_pready,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [PortWidth-1:0]     evt_status,
    output logic [TS_W-1:0]          evt_ts,
    output logic [$clog2(DEPTH):0]   evt_count,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam int EW = TS_W + PortWidth;

    // Word address of the GPIO Interrupt State register (byte offset 0x18).
    localparam logic [5:0] INT_STATE_WADDR = 6'h06;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RD_SETUP  = 3'd1,
        S_RD_ACCESS = 3'd2,
        S_WR_SETUP  = 3'd3,
        S_WR_ACCESS = 3'd4,
        S_PUSH      = 3'd5,
        S_HOLD      = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic [PortWidth-1:0]  cap_status_q, cap_status_d;
    logic [TS_W-1:0]       cap_ts_q, cap_ts_d;
    logic [TS_W-1:0]       ts_q;

    logic                  psel_q, penable_q, pwrite_q;
    logic [5:0]            paddr_q;
    logic [31:0]           pwdata_q;

    logic                  in_xfer_d, in_access_d, in_write_d;

    logic [EW-1:0]         fifo_mem [DEPTH];
    logic [AW-1:0]         wptr_q, rptr_q;
    logic [CW-1:0]         count_q;
    logic                  fifo_full, fifo_empty, push, pop;
    logic [EW-1:0]         head;

    logic [PortWidth-1:0]  rd_status;
    logic                  unused_prdata;

    assign rd_status     = m_prdata[PortWidth-1:0];
    // Only the low PortWidth bits of Interrupt State are meaningful.
    assign unused_prdata = ^m_prdata[31:PortWidth];

    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    // A service only starts with a free slot and the FIFO cannot grow while
    // the sequence runs, so PUSH always has room.
    assign push       = (state_q == S_PUSH);
    assign pop        = !fifo_empty && evt_ready;

    // Free-running timestamp, wraps naturally at 2^TS_W.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    // Service FSM: state, hold-off counter and capture registers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q      <= S_IDLE;
            hold_q       <= '0;
            cap_status_q <= '0;
            cap_ts_q     <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            cap_status_q <= cap_status_d;
            cap_ts_q     <= cap_ts_d;
        end
    end

    // Next-state logic; the read result is captured on the completing cycle.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        cap_status_d = cap_status_q;
        cap_ts_d     = cap_ts_q;
        case (state_q)
            S_IDLE: begin
                // A full FIFO leaves the bits pending in the GPIO block.
                if (en && combint && !fifo_full) begin
                    state_d = S_RD_SETUP;
                end
            end
            S_RD_SETUP: begin
                state_d = S_RD_ACCESS;
            end
            S_RD_ACCESS: begin
                if (m_pready) begin
                    cap_status_d = rd_status;
                    cap_ts_d     = ts_q;
                    if (rd_status == '0) begin
                        // Spurious interrupt: nothing to clear or record.
                        state_d = S_HOLD;
                        hold_d  = HW'(HOLDOFF);
                    end else begin
                        state_d = S_WR_SETUP;
                    end
                end
            end
            S_WR_SETUP: begin
                state_d = S_WR_ACCESS;
            end
            S_WR_ACCESS: begin
                if (m_pready) begin
                    state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                state_d = S_HOLD;
                hold_d  = HW'(HOLDOFF);
            end
            S_HOLD: begin
                // Gives combint time to fall after the W1C before re-sampling.
                if (hold_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Decode of the upcoming state, used to register the APB outputs.
    always_comb begin
        in_xfer_d   = (state_d == S_RD_SETUP) || (state_d == S_RD_ACCESS) ||
                      (state_d == S_WR_SETUP) || (state_d == S_WR_ACCESS);
        in_access_d = (state_d == S_RD_ACCESS) || (state_d == S_WR_ACCESS);
        in_write_d  = (state_d == S_WR_SETUP) || (state_d == S_WR_ACCESS);
    end

    // Registered APB master outputs, aligned with the state they belong to.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            psel_q    <= in_xfer_d;
            penable_q <= in_access_d;
            pwrite_q  <= in_write_d;
            paddr_q   <= in_xfer_d ? INT_STATE_WADDR : 6'h00;
            // W1C data: exactly the bits that were read as set.
            pwdata_q  <= in_write_d ? 32'(cap_status_d) : 32'h0;
        end
    end

    assign m_psel    = psel_q;
    assign m_penable = penable_q;
    assign m_pwrite  = pwrite_q;
    assign m_paddr   = paddr_q;
    assign m_pwdata  = pwdata_q;
    assign busy      = (state_q != S_IDLE);

    // Event storage; contents need no reset since empty entries are masked.
    always_ff @(posedge PCLK) begin
        if (push) begin
            fifo_mem[wptr_q] <= {cap_ts_q, cap_status_q};
        end
    end

    // FIFO pointers and occupancy; pointers wrap modulo DEPTH.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head       = fifo_mem[rptr_q];
    assign evt_valid  = !fifo_empty;
    assign evt_count  = count_q;
    assign evt_status = fifo_empty ? '0 : head[PortWidth-1:0];
    assign evt_ts     = fifo_empty ? '0 : head[EW-1:PortWidth];

endmodule
